// File: rtl/pipe_reg_chain.sv
// Elastic chain of DEPTH valid/ready pipeline registers.
// Bubbles collapse forward, and a per-stage flush mask empties selected stages to FLUSH_VALUE.
module pipe_reg_chain #(
   parameter int               WIDTH       = 200,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}}
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   input  logic [DEPTH-1:0]             flush_mask,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]             r_valid;
   logic [DEPTH-1:0][WIDTH-1:0]  r_data;
   logic [OCC_W-1:0]             r_occupancy;

   logic [DEPTH:0]               w_ready;
   logic [DEPTH-1:0]             w_upValid;
   logic [DEPTH-1:0][WIDTH-1:0]  w_upData;
   logic [DEPTH-1:0]             w_incoming;
   logic [DEPTH-1:0]             w_nextValid;
   logic [DEPTH-1:0][WIDTH-1:0]  w_nextData;
   logic [OCC_W-1:0]             w_nextOcc;

   // Ready ripples from the output back to stage 0, so a stage whose item is about
   // to leave can take a new one on the same edge. Flush never affects readiness.
   always_comb begin
      w_ready        = '0;
      w_upValid      = '0;
      w_upData       = '0;
      w_incoming     = '0;
      w_nextValid    = r_valid;
      w_nextData     = r_data;
      w_nextOcc      = '0;

      w_ready[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_ready[i] = !r_valid[i] || w_ready[i+1];
      end

      w_upValid[0] = in_valid;
      w_upData[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         w_upValid[i] = r_valid[i-1];
         w_upData[i]  = r_data[i-1];
      end

      for (int i = 0; i < DEPTH; i++) begin
         w_incoming[i] = w_upValid[i] && w_ready[i];
         if (flush_mask[i]) begin
            w_nextValid[i] = 1'b0;
            w_nextData[i]  = FLUSH_VALUE;
         end else if (w_incoming[i]) begin
            w_nextValid[i] = 1'b1;
            w_nextData[i]  = w_upData[i];
         end else if (r_valid[i] && w_ready[i+1]) begin
            w_nextValid[i] = 1'b0;
            w_nextData[i]  = FLUSH_VALUE;
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         w_nextOcc = w_nextOcc + OCC_W'(w_nextValid[i]);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_valid     <= '0;
         r_data      <= {DEPTH{FLUSH_VALUE}};
         r_occupancy <= '0;
      end else begin
         r_valid     <= w_nextValid;
         r_data      <= w_nextData;
         r_occupancy <= w_nextOcc;
      end
   end

   assign in_ready  = w_ready[0];
   assign out_valid = r_valid[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=32, DEPTH=3, FLUSH_VALUE=32'h13): directed scenarios plus
// random traffic, compared against an item-level model of the chain's contents.
module tb_pipe_reg_chain;

   localparam int          WIDTH = 32;
   localparam int          DEPTH = 3;
   localparam logic [31:0] FLUSH = 32'h13;

   logic              Clk = 1'b0;
   logic              Rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [DEPTH-1:0]  flush_mask;
   logic [1:0]        occupancy;

   int total = 0;
   int bad   = 0;

   // Model: which stages hold an item and what it is
   bit          mValid[DEPTH];
   logic [31:0] mData[DEPTH];

   pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLUSH_VALUE(FLUSH)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flush_mask(flush_mask), .occupancy(occupancy)
   );

   always #5 Clk = ~Clk;

   // The chain accepts when any stage is a bubble or the output drains.
   function automatic bit modelReady();
      bit r;
      r = out_ready;
      for (int i = 0; i < DEPTH; i++) if (!mValid[i]) r = 1'b1;
      return r;
   endfunction

   function automatic logic [35:0] modelOut();
      logic [1:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + 2'(mValid[i]);
      return {mValid[DEPTH-1] ? 1'b1 : 1'b0,
              mValid[DEPTH-1] ? mData[DEPTH-1] : FLUSH,
              modelReady() ? 1'b1 : 1'b0, cnt};
   endfunction

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) begin
         mValid[i] = 1'b0;
         mData[i]  = FLUSH;
      end
   endtask

   // Items move forward when the slot ahead is free or is itself being vacated;
   // flushed slots end up empty regardless of what moved into them.
   task automatic modelEdge();
      bit          moved[DEPTH];
      bit          nv[DEPTH];
      logic [31:0] nd[DEPTH];
      bit          acc;
      acc = in_valid && modelReady();
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i == DEPTH - 1) moved[i] = mValid[i] && out_ready;
         else                moved[i] = mValid[i] && (!mValid[i+1] || moved[i+1]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         nv[i] = 1'b0;
         nd[i] = FLUSH;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (mValid[i] && !moved[i]) begin
            nv[i] = 1'b1;
            nd[i] = mData[i];
         end else if (moved[i] && i < DEPTH - 1) begin
            nv[i+1] = 1'b1;
            nd[i+1] = mData[i];
         end
      end
      if (acc) begin
         nv[0] = 1'b1;
         nd[0] = in_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (flush_mask[i]) begin
            nv[i] = 1'b0;
            nd[i] = FLUSH;
         end
         mValid[i] = nv[i];
         mData[i]  = nd[i];
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic [2:0] fm);
      in_valid   = iv;
      in_data    = id;
      out_ready  = ordy;
      flush_mask = fm;
      #1;
   endtask

   task automatic tick();
      @(posedge Clk);
      modelEdge();
      @(negedge Clk);
   endtask

   task automatic doReset();
      Rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 3'b000);
      modelReset();
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [35:0] exp;
      doReset();
      drive(1'b0, 32'h0, 1'b0, 3'b000);
      total++;
      if ({out_valid, out_data, in_ready, occupancy} !== {1'b0, FLUSH, 1'b1, 2'd0}) begin
         bad++;
         $display("[TB] FAIL reset_idle: got %h want %h", {out_valid, out_data, in_ready, occupancy}, {1'b0, FLUSH, 1'b1, 2'd0});
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'hA000 + k, 1'b0, 3'b000);
         exp = modelOut();
         total++;
         if ({out_valid, out_data, in_ready, occupancy} !== exp) begin
            bad++;
            $display("[TB] FAIL reset_prefill cyc %0d: got %h want %h", k, {out_valid, out_data, in_ready, occupancy}, exp);
         end
         tick();
      end
      // Chain is full and stalled; reset must clear it without waiting for a clock edge
      drive(1'b1, 32'hBEEF, 1'b0, 3'b000);
      #2 Rst_n = 1'b0;
      #1;
      modelReset();
      total++;
      if ({out_valid, out_data, in_ready, occupancy} !== {1'b0, FLUSH, 1'b1, 2'd0}) begin
         bad++;
         $display("[TB] FAIL reset_async: got %h want %h", {out_valid, out_data, in_ready, occupancy}, {1'b0, FLUSH, 1'b1, 2'd0});
      end
      @(posedge Clk);
      #1;
      total++;
      if ({out_valid, out_data, in_ready, occupancy} !== {1'b0, FLUSH, 1'b1, 2'd0}) begin
         bad++;
         $display("[TB] FAIL reset_held: got %h want %h", {out_valid, out_data, in_ready, occupancy}, {1'b0, FLUSH, 1'b1, 2'd0});
      end
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic test_streaming();
      logic [35:0] exp;
      doReset();
      for (int k = 1; k <= 12; k++) begin
         drive(1'b1, 32'(k), 1'b1, 3'b000);
         exp = modelOut();
         total++;
         if ({out_valid, out_data, in_ready, occupancy} !== exp) begin
            bad++;
            $display("[TB] FAIL stream cyc %0d: got %h want %h", k, {out_valid, out_data, in_ready, occupancy}, exp);
         end
         // item 1 accepted at edge 1 shows up after edge 3; then one per cycle
         if (k >= 4) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'(k - 3)) begin
               bad++;
               $display("[TB] FAIL stream_order cyc %0d: got %0b/%h want 1/%h", k, out_valid, out_data, 32'(k - 3));
            end
         end
         if (k == 8) begin
            total++;
            if (occupancy !== 2'd3) begin
               bad++;
               $display("[TB] FAIL stream_occ: got %0d want 3", occupancy);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] expSeq[3];
      doReset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'hA0 + k, 1'b0, 3'b000);
         tick();
      end
      drive(1'b1, 32'hD0, 1'b0, 3'b000);
      total++;
      if ({in_ready, out_valid, out_data, occupancy} !== {1'b0, 1'b1, 32'hA0, 2'd3}) begin
         bad++;
         $display("[TB] FAIL bp_full: got %h want %h", {in_ready, out_valid, out_data, occupancy}, {1'b0, 1'b1, 32'hA0, 2'd3});
      end
      tick();
      drive(1'b1, 32'hD0, 1'b0, 3'b000);
      total++;
      if (out_data !== 32'hA0) begin
         bad++;
         $display("[TB] FAIL bp_hold: got %h want %h", out_data, 32'hA0);
      end
      drive(1'b1, 32'hD0, 1'b1, 3'b000);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_passthrough_ready: got %0b want 1", in_ready);
      end
      tick();
      expSeq = '{32'hA1, 32'hA2, 32'hD0};
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 32'h0, 1'b1, 3'b000);
         total++;
         if (out_valid !== 1'b1 || out_data !== expSeq[k] || (k == 0 && occupancy !== 2'd3)) begin
            bad++;
            $display("[TB] FAIL bp_order %0d: got %0b/%h occ %0d want 1/%h", k, out_valid, out_data, occupancy, expSeq[k]);
         end
         tick();
      end
   endtask

   task automatic test_bubble();
      doReset();
      drive(1'b1, 32'hAA, 1'b0, 3'b000);
      tick();
      drive(1'b0, 32'h0, 1'b0, 3'b000);
      tick();
      tick();
      drive(1'b1, 32'hBB, 1'b0, 3'b000);
      tick();
      drive(1'b0, 32'h0, 1'b0, 3'b000);
      tick();
      total++;
      if ({out_valid, out_data, in_ready, occupancy} !== {1'b1, 32'hAA, 1'b1, 2'd2}) begin
         bad++;
         $display("[TB] FAIL bubble_state: got %h want %h", {out_valid, out_data, in_ready, occupancy}, {1'b1, 32'hAA, 1'b1, 2'd2});
      end
      drive(1'b0, 32'h0, 1'b1, 3'b000);
      tick();
      drive(1'b0, 32'h0, 1'b1, 3'b000);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hBB) begin
         bad++;
         $display("[TB] FAIL bubble_advance: got %0b/%h want 1/%h", out_valid, out_data, 32'hBB);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [35:0] exp;
      doReset();
      drive(1'b1, 32'hCC, 1'b0, 3'b000); tick();
      drive(1'b1, 32'hBB, 1'b0, 3'b000); tick();
      drive(1'b1, 32'hAA, 1'b0, 3'b000); tick();
      drive(1'b1, 32'hDD, 1'b1, 3'b011);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hCC || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL flush_pre: got %0b/%h rdy %0b want 1/%h rdy 1", out_valid, out_data, in_ready, 32'hCC);
      end
      tick();
      drive(1'b0, 32'h0, 1'b0, 3'b000);
      exp = modelOut();
      total++;
      if ({out_valid, out_data, in_ready, occupancy} !== {1'b1, 32'hBB, 1'b1, 2'd1} ||
          {out_valid, out_data, in_ready, occupancy} !== exp) begin
         bad++;
         $display("[TB] FAIL flush_post: got %h want %h", {out_valid, out_data, in_ready, occupancy}, {1'b1, 32'hBB, 1'b1, 2'd1});
      end
      drive(1'b0, 32'h0, 1'b1, 3'b000);
      tick();
      tick();
      total++;
      if ({out_valid, out_data, occupancy} !== {1'b0, FLUSH, 2'd0}) begin
         bad++;
         $display("[TB] FAIL flush_dropped: got %h want %h", {out_valid, out_data, occupancy}, {1'b0, FLUSH, 2'd0});
      end
   endtask

   task automatic test_full_flush();
      doReset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'hE0 + k, 1'b0, 3'b000);
         tick();
      end
      drive(1'b1, 32'hEF, 1'b0, 3'b111);
      tick();
      drive(1'b0, 32'h0, 1'b0, 3'b000);
      total++;
      if ({out_valid, out_data, in_ready, occupancy} !== {1'b0, FLUSH, 1'b1, 2'd0}) begin
         bad++;
         $display("[TB] FAIL full_flush: got %h want %h", {out_valid, out_data, in_ready, occupancy}, {1'b0, FLUSH, 1'b1, 2'd0});
      end
   endtask

   task automatic test_random();
      logic [35:0] exp;
      logic [2:0]  fm;
      doReset();
      for (int k = 0; k < 500; k++) begin
         fm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 9) < 6), fm);
         exp = modelOut();
         total++;
         if ({out_valid, out_data, in_ready, occupancy} !== exp) begin
            bad++;
            $display("[TB] FAIL random cyc %0d: got %h want %h", k, {out_valid, out_data, in_ready, occupancy}, exp);
         end
         tick();
      end
   endtask

   initial begin
      Rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      flush_mask = '0;
      @(negedge Clk);
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_flush();
      test_full_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
